// File: rtl/seq_scan_arbiter_if.sv
// Requester, config and result bus of seq_scan_arbiter.
// Defining SEQ_FIRST_MATCH_EN adds the first_only request qualifier.
interface seq_scan_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int PMAX  = 8
);
  logic                       cfg_we;
  logic [PMAX-1:0]            cfg_pat;
  logic [$clog2(PMAX+1)-1:0]  cfg_len;
  logic [NREQ-1:0]            req;
  logic [NREQ*WIDTH-1:0]      data;
  logic [NREQ-1:0]            gnt;
  logic                       busy;
  logic                       match_pulse;
  logic                       done;
  logic [$clog2(NREQ)-1:0]    done_id;
  logic [$clog2(WIDTH+1)-1:0] match_cnt;
`ifdef SEQ_FIRST_MATCH_EN
  logic                       first_only;

  modport master (
    output cfg_we, cfg_pat, cfg_len, req, data, first_only,
    input  gnt, busy, match_pulse, done, done_id, match_cnt
  );
  modport slave (
    input  cfg_we, cfg_pat, cfg_len, req, data, first_only,
    output gnt, busy, match_pulse, done, done_id, match_cnt
  );
`else
  modport master (
    output cfg_we, cfg_pat, cfg_len, req, data,
    input  gnt, busy, match_pulse, done, done_id, match_cnt
  );
  modport slave (
    input  cfg_we, cfg_pat, cfg_len, req, data,
    output gnt, busy, match_pulse, done, done_id, match_cnt
  );
`endif
endinterface

// File: rtl/seq_scan_arbiter.sv
// Round-robin shared overlapping pattern matcher: one granted word is scanned MSB-first per turn.
// Optional SEQ_FIRST_MATCH_EN: first_only sampled at grant ends the scan at the first match.
module seq_scan_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int PMAX  = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_scan_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int LW = $clog2(PMAX+1);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [PMAX-1:0] pat, hist, hist_nxt, mask;
  logic [LW-1:0]   len;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]   bit_cnt;
  logic [IW-1:0]   ptr, win, id;
  logic            any_req, grant, match, stop_early, shift_en;

`ifdef SEQ_FIRST_MATCH_EN
  logic fo_q;
  // The registered pulse marks the first match; the scan stops before shifting again.
  assign stop_early = fo_q & bus.match_pulse;
`else
  assign stop_early = 1'b0;
`endif

  // First requester at or after the pointer, wrapping (NREQ is a power of two).
  always_comb begin
    win     = ptr;
    any_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req && bus.req[ptr + IW'(i)]) begin
        any_req = 1'b1;
        win     = ptr + IW'(i);
      end
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PMAX; i++) mask[i] = (32'(i) < 32'(len));
  end

  assign hist_nxt = (hist << 1) | PMAX'(sreg[WIDTH-1]);
  assign match    = (((hist_nxt ^ pat) & mask) == '0) && (32'(bit_cnt) + 32'd1 >= 32'(len));
  assign shift_en = (state == SHIFT) && !stop_early;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    unique case (state)
      IDLE:  if (any_req) begin
               state_nxt = SHIFT;
               grant     = 1'b1;
             end
      SHIFT: if (stop_early || (32'(bit_cnt) + 32'd1 >= WIDTH)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      id              <= '0;
      pat             <= '0;
      len             <= LW'(1);
      hist            <= '0;
      sreg            <= '0;
      bit_cnt         <= '0;
      bus.gnt         <= '0;
      bus.busy        <= 1'b0;
      bus.match_pulse <= 1'b0;
      bus.done        <= 1'b0;
      bus.done_id     <= '0;
      bus.match_cnt   <= '0;
`ifdef SEQ_FIRST_MATCH_EN
      fo_q            <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      bus.busy        <= (state_nxt != IDLE);
      bus.gnt         <= '0;
      bus.match_pulse <= 1'b0;
      bus.done        <= 1'b0;

      // A write in the grant cycle lands before the first compare, so the scan sees it.
      if (state == IDLE && bus.cfg_we && bus.cfg_len != '0) begin
        pat <= bus.cfg_pat;
        len <= (32'(bus.cfg_len) > PMAX) ? LW'(PMAX) : bus.cfg_len;
      end

      if (grant) begin
        sreg          <= bus.data[win*WIDTH +: WIDTH];
        hist          <= '0;
        bit_cnt       <= '0;
        id            <= win;
        ptr           <= win + 1'b1;
        bus.gnt[win]  <= 1'b1;
        bus.match_cnt <= '0;
`ifdef SEQ_FIRST_MATCH_EN
        fo_q          <= bus.first_only;
`endif
      end

      if (shift_en) begin
        sreg    <= sreg << 1;
        hist    <= hist_nxt;
        bit_cnt <= bit_cnt + 1'b1;
        if (match) begin
          bus.match_pulse <= 1'b1;
          bus.match_cnt   <= bus.match_cnt + 1'b1;
        end
      end

      if (state == SHIFT && state_nxt == DONE) begin
        bus.done    <= 1'b1;
        bus.done_id <= id;
      end
    end
  end
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Directed bench for seq_scan_arbiter: pattern counts, RR order, config gating, reset mid-scan.
module tb_seq_scan_arbiter;
  localparam int NREQ = 4, WIDTH = 16, PMAX = 8;

  logic clk, rst;
  int   n_chk, n_pass;

  seq_scan_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .PMAX(PMAX)) bus ();
  seq_scan_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .PMAX(PMAX)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the last scan, offsets in cycles relative to the gnt cycle.
  logic [31:0] pmask;
  logic [3:0]  r_gnt;
  int          done_off;
  logic [1:0]  r_id;
  logic [4:0]  r_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_pat = p; bus.cfg_len = l;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // cmode: 0 plain, 1 config write alongside req, 2 config write in first SHIFT cycle
  task automatic scan(input int r, input logic [15:0] w, input int cmode,
                      input logic [7:0] cp, input logic [3:0] cl);
    int gk;
    bit seen;
    @(negedge clk);
    bus.data[r*WIDTH +: WIDTH] = w;
    bus.req[r] = 1'b1;
    if (cmode == 1) begin bus.cfg_we = 1'b1; bus.cfg_pat = cp; bus.cfg_len = cl; end
    gk = -1; seen = 1'b0; pmask = '0; r_gnt = '0; done_off = -1;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      bus.cfg_we = 1'b0;
      if (bus.gnt != '0 && gk < 0) begin
        gk = k; r_gnt = bus.gnt; bus.req[r] = 1'b0;
        if (cmode == 2) begin bus.cfg_we = 1'b1; bus.cfg_pat = cp; bus.cfg_len = cl; end
      end
      if (bus.match_pulse && gk >= 0) pmask[k-gk] = 1'b1;
      if (bus.done) begin
        seen = 1'b1; done_off = k - gk; r_id = bus.done_id; r_cnt = bus.match_cnt;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int k = 0; k < 60 && !idle; k++) begin
      @(negedge clk);
      idle = !bus.busy;
    end
    chk("idle_reached", 32'(idle), 32'd1);
  endtask

  initial begin
    logic [3:0] order [5];
    int ng;
    n_chk = 0; n_pass = 0;
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_pat = '0; bus.cfg_len = '0;
    bus.req = '0; bus.data = '0;
`ifdef SEQ_FIRST_MATCH_EN
    bus.first_only = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pulse", 32'(bus.match_pulse), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_done_id", 32'(bus.done_id), 32'd0);
    chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
    rst = 1'b0;

    // 11011 on DB00: matches end at bits 4 and 7
    cfg(8'h1B, 4'd5);
    scan(0, 16'hDB00, 0, 8'h00, 4'd0);
    chk("p11011_gnt", 32'(r_gnt), 32'h1);
    chk("p11011_pulses", pmask, (32'd1 << 5) | (32'd1 << 8));
    chk("p11011_done_off", 32'(done_off), 32'd16);
    chk("p11011_id", 32'(r_id), 32'd0);
    chk("p11011_cnt", 32'(r_cnt), 32'd2);
    @(negedge clk);
    chk("hold_cnt", 32'(bus.match_cnt), 32'd2);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Dense overlap and the no-match case
    cfg(8'h03, 4'd2);
    scan(1, 16'hFFFF, 0, 8'h00, 4'd0);
    chk("dense_cnt", 32'(r_cnt), 32'd15);
    chk("dense_id", 32'(r_id), 32'd1);
    scan(2, 16'h0000, 0, 8'h00, 4'd0);
    chk("zero_cnt", 32'(r_cnt), 32'd0);
    chk("zero_done_off", 32'(done_off), 32'd16);
    chk("zero_id", 32'(r_id), 32'd2);

    // Config gating: write during SHIFT ignored, len=0 ignored, len=12 clamps to 8
    scan(3, 16'hFF00, 2, 8'hFF, 4'd8);
    chk("midcfg_cnt", 32'(r_cnt), 32'd7);
    chk("midcfg_gnt", 32'(r_gnt), 32'h8);
    cfg(8'hFF, 4'd0);
    scan(0, 16'hFF00, 0, 8'h00, 4'd0);
    chk("len0_cnt", 32'(r_cnt), 32'd7);
    cfg(8'hFF, 4'd12);
    scan(1, 16'hFF00, 0, 8'h00, 4'd0);
    chk("len12_cnt", 32'(r_cnt), 32'd1);
    // Config written in the grant cycle applies to that scan
    scan(2, 16'hA800, 1, 8'h05, 4'd3);
    chk("samecyc_cnt", 32'(r_cnt), 32'd2);

    // Reset in the 5th SHIFT cycle
    cfg(8'h03, 4'd2);
    @(negedge clk);
    bus.data[3*WIDTH +: WIDTH] = 16'hFFFF;
    bus.req[3] = 1'b1;
    @(negedge clk);
    chk("mid_gnt", 32'(bus.gnt), 32'h8);
    bus.req[3] = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_cnt_before", 32'(bus.match_cnt), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_cnt", 32'(bus.match_cnt), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    bus.req = 4'b1111;
    @(negedge clk);
    chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    wait_idle();

    // Round-robin with all requesters active
    do_reset();
    bus.req = 4'b1111;
    ng = 0;
    for (int k = 0; k < 200 && ng < 5; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        order[ng] = bus.gnt; ng++;
        bus.req = bus.req & ~bus.gnt;
      end else begin
        bus.req = 4'b1111;
      end
    end
    bus.req = '0;
    chk("rr_count", 32'(ng), 32'd5);
    chk("rr_0", 32'(order[0]), 32'h1);
    chk("rr_1", 32'(order[1]), 32'h2);
    chk("rr_2", 32'(order[2]), 32'h4);
    chk("rr_3", 32'(order[3]), 32'h8);
    chk("rr_4", 32'(order[4]), 32'h1);
    wait_idle();

    do_reset();
    bus.req = 4'b1100;
    @(negedge clk);
    chk("rr_first_2", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    wait_idle();

`ifdef SEQ_FIRST_MATCH_EN
    cfg(8'h1B, 4'd5);
    bus.first_only = 1'b1;
    scan(0, 16'hDB00, 0, 8'h00, 4'd0);
    bus.first_only = 1'b0;
    chk("first_done_off", 32'(done_off), 32'd6);
    chk("first_cnt", 32'(r_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
